fifo_drain_sched: RTL and testbench
===================================

// Module: fifo_drain_sched
// PURPOSE
// - Round-robin scheduler draining NUM_Q independent fifo instances into one valid/ready output stream.
// - Sits between the per-source fifos (pop / is_empty / o_data, head shown combinationally) and the single downstream consumer.
// - Grants one queue at a time for a burst of at most BURST_MAX words.
// - Tags each output word with its source queue id.
// PARAMETERS
// - NUM_Q      4  number of source fifos, 2..8
// - QID_W      2  width of queue id; must equal clog2(NUM_Q)
// - DW         8  data width; must match the fifo data_size
// - BURST_MAX  4  max words popped per grant, 1..255
// PORTS
// - clk        in   1         clock, rising edge
// - rst_n      in   1         asynchronous active-low reset
// - enable     in   1         1 = scheduling allowed
// - q_empty    in   NUM_Q     is_empty of each fifo; bit i = queue i
// - q_data     in   NUM_Q*DW  o_data of each fifo; queue i at [i*DW +: DW]
// - q_pop      out  NUM_Q     one-hot pop, single-cycle pulse per word
// - out_valid  out  1         output register holds a word
// - out_data   out  DW        output word
// - out_qid    out  QID_W     source queue of out_data
// - out_ready  in   1         consumer accepts word when out_valid & out_ready
// - busy       out  1         FSM not in IDLE
// BEHAVIOUR
// - Reset: state=IDLE, grant=0, rr_ptr=NUM_Q-1, burst_cnt=0.
//   out_valid=0, out_data=0, out_qid=0, q_pop=0, busy=0.
// - Output register drains when out_valid & out_ready.
// - Output register can load when !out_valid | out_ready.
// - Pop rule: q_pop[grant] = (state==SERVE) & enable & !q_empty[grant] & can_load. The pop is combinational.
//   On that edge the register loads out_data <= q_data[grant], out_qid <= grant, out_valid <= 1.
// - No pop is ever issued to an empty queue. At most one q_pop bit is high in any cycle.
// - If the register drains with no load, out_valid <= 0.
// - out_data and out_qid hold while out_valid & !out_ready.
// - IDLE
//   - If enable and any queue is non-empty: pick the first non-empty queue scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_Q.
//   - grant <= pick, rr_ptr <= pick, burst_cnt <= 0, go to SERVE.
// - SERVE
//   - Each pop increments burst_cnt (8-bit).
//   - Return to IDLE when a pop occurs with burst_cnt==BURST_MAX-1.
//   - Return to IDLE when q_empty[grant]=1 and no pop occurs in that cycle.
//   - Return to IDLE when enable=0. A word already in the output register stays and still drains normally.
// - Latency: a word at the head of an idle queue appears on out_valid 2 cycles after q_empty falls (IDLE->SERVE, then load).
//   Sustained throughput within a burst is 1 word/cycle while out_ready=1.
// - Fairness: after a grant to queue k, the next grant scans from k+1. A queue left non-empty waits at most NUM_Q-1 other grants.
// - Back-pressure: while out_ready=0 and out_valid=1, no pop occurs and SERVE holds. The burst is neither lost nor reset.
// - Wrap-around: the rr scan crosses NUM_Q-1 to 0. rr_ptr increments modulo NUM_Q, not modulo 2^QID_W.
// - Simultaneous: a drain and a load in the same cycle keep out_valid=1 with the new word.
// - A single non-empty queue is re-granted by itself after each burst, with one IDLE cycle between bursts.
// - Reset mid-burst clears all state immediately. Any word in the output register is discarded.
// STRUCTURE
// - sched_pkg
//   - localparams for state encoding: ST_IDLE=1'b0, ST_SERVE=1'b1.
//   - BURST_CNT_W=8.
//   - Function clog2 for checking QID_W.
// - Sub-module rr_pick: combinational round-robin picker.
//   - Inputs: req[NUM_Q], ptr[QID_W].
//   - Outputs: pick[QID_W], any.
//   - Priority order starts at ptr+1.
// - Top level holds the FSM, burst counter and output register. q_data is muxed by grant.
// TESTING (bench instantiates 4 fifo instances, DW=8, BURST_MAX=4)
// - Reset, then q0 holds 0x11,0x22 with out_ready=1:
//   - q_pop[0] pulses twice on consecutive cycles.
//   - out_data is 0x11 then 0x22 with qid=0.
//   - FSM returns to IDLE on empty.
// - q1 and q3 each hold 6 words:
//   - Output order is q1 x4, q3 x4, q1 x2, q3 x2.
//   - No pop is issued to an empty queue.
// - out_ready=0 for 5 cycles mid-burst:
//   - out_valid stays 1 and out_data is stable.
//   - q_pop stays 0.
//   - The burst resumes without loss or duplication.
// - enable deasserted mid-burst on q2:
//   - No further pops.
//   - The pending word drains.
//   - On re-enable, the scan resumes from q3.
// - rr_ptr=3 with q0 and q2 non-empty:
//   - The next grant is q0, verifying wrap-around.
// - Assert rst_n=0 during a burst:
//   - All outputs go to 0 within the reset cycle.
//   - After release, the first grant follows the scan order from q0.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared definitions for the round-robin fifo drain scheduler.
package sched_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } sched_state_e;

  localparam int BURST_CNT_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo NUM_Q.
module rr_pick
  import sched_pkg::*;
#(
  parameter int NUM_Q = 4,
  parameter int QID_W = 2
) (
  input  logic [NUM_Q-1:0] req,
  input  logic [QID_W-1:0] ptr,
  output logic [QID_W-1:0] pick,
  output logic             any
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int idx;
    idx  = 0;
    pick = '0;
    for (int off = NUM_Q; off >= 1; off--) begin
      idx = (int'(ptr) + off) % NUM_Q;
      if (req[idx]) pick = QID_W'(idx);
    end
  end

  assign any = |req;

endmodule

// File: rtl/fifo_drain_sched.sv
// Drains NUM_Q fifos round-robin, in bursts of up to BURST_MAX words, into one
// valid/ready stream tagged with the source queue id.
module fifo_drain_sched
  import sched_pkg::*;
#(
  parameter int NUM_Q     = 4,
  parameter int QID_W     = 2,
  parameter int DW        = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [NUM_Q-1:0]    q_empty,
  input  logic [NUM_Q*DW-1:0] q_data,
  output logic [NUM_Q-1:0]    q_pop,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  output logic [QID_W-1:0]    out_qid,
  input  logic                out_ready,
  output logic                busy
);

  if (QID_W != clog2(NUM_Q)) begin : g_qid_chk
    $error("QID_W must equal clog2(NUM_Q)");
  end
  if (BURST_MAX < 1 || BURST_MAX > 255) begin : g_burst_chk
    $error("BURST_MAX must be within 1..255");
  end

  sched_state_e           state_q;
  logic [QID_W-1:0]       grant_q;
  logic [QID_W-1:0]       rr_ptr_q;
  logic [BURST_CNT_W-1:0] burst_cnt_q;
  logic                   out_valid_q;
  logic [DW-1:0]          out_data_q;
  logic [QID_W-1:0]       out_qid_q;

  logic [QID_W-1:0] pick;
  logic             any;
  logic             head_empty;
  logic [DW-1:0]    head_data;
  logic             can_load;
  logic             pop;
  logic             last_word;

  rr_pick #(
    .NUM_Q(NUM_Q),
    .QID_W(QID_W)
  ) u_pick (
    .req (~q_empty),
    .ptr (rr_ptr_q),
    .pick(pick),
    .any (any)
  );

  assign head_empty = q_empty[grant_q];
  assign head_data  = q_data[int'(grant_q)*DW +: DW];
  assign can_load   = !out_valid_q || out_ready;
  assign pop        = (state_q == ST_SERVE) && enable && !head_empty && can_load;
  assign last_word  = (burst_cnt_q == BURST_CNT_W'(BURST_MAX - 1));

  // Pop is combinational so the word is captured on the same edge it is popped.
  assign q_pop = pop ? (NUM_Q'(1) << grant_q) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= QID_W'(NUM_Q - 1);
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable && any) begin
            grant_q     <= pick;
            rr_ptr_q    <= pick;
            burst_cnt_q <= '0;
            state_q     <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (pop) burst_cnt_q <= burst_cnt_q + BURST_CNT_W'(1);
          // Back-pressure (no pop, queue still non-empty) simply holds SERVE.
          if (!enable)                state_q <= ST_IDLE;
          else if (pop && last_word)  state_q <= ST_IDLE;
          else if (!pop && head_empty) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_qid_q   <= '0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      out_data_q  <= head_data;
      out_qid_q   <= grant_q;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_qid   = out_qid_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_drain_sched.sv
// Bench for fifo_drain_sched: behavioural fifos, table vectors, corner sequences, random trials.
module tb_fifo_drain_sched;
  localparam int NQ   = 4;
  localparam int QW   = 2;
  localparam int DW   = 8;
  localparam int BMAX = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [NQ-1:0]     q_empty;
  logic [NQ*DW-1:0]  q_data;
  logic [NQ-1:0]     q_pop;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [QW-1:0]     out_qid;
  logic              out_ready;
  logic              busy;

  always #5 clk = ~clk;

  fifo_drain_sched #(.NUM_Q(NQ), .QID_W(QW), .DW(DW), .BURST_MAX(BMAX)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .q_empty(q_empty), .q_data(q_data),
    .q_pop(q_pop), .out_valid(out_valid), .out_data(out_data), .out_qid(out_qid),
    .out_ready(out_ready), .busy(busy)
  );

  typedef struct {
    int    c0, c1, c2, c3;
    string seq;
  } vec_t;

  logic [7:0]  fq[NQ][$];
  logic [7:0]  src[NQ][$];
  logic [15:0] got[$];
  logic [15:0] exp_q[$];
  int n_pass = 0, n_total = 0, legal_err = 0;
  bit rand_ready = 0;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic logic [7:0] dat(input int q, input int k);
    return 8'(q * 64 + k);
  endfunction

  function automatic vec_t mk(input int a, input int b, input int c, input int d, input string s);
    vec_t v;
    v.c0 = a; v.c1 = b; v.c2 = c; v.c3 = d; v.seq = s;
    return v;
  endfunction

  task automatic drive_fifos();
    for (int i = 0; i < NQ; i++) begin
      q_empty[i]          = (fq[i].size() == 0);
      q_data[i*DW +: DW]  = (fq[i].size() != 0) ? fq[i][0] : 8'h00;
    end
  endtask

  task automatic settle();
    drive_fifos();
    #1;
  endtask

  task automatic adv();
    logic [NQ-1:0] popped;
    logic [7:0]    tmp;
    if ((q_pop & q_empty) != '0) legal_err++;
    if ($countones(q_pop) > 1) legal_err++;
    if (q_pop != '0 && out_valid && !out_ready) legal_err++;
    popped = q_pop;
    if (out_valid && out_ready) got.push_back({6'b0, out_qid, out_data});
    @(posedge clk);
    for (int i = 0; i < NQ; i++)
      if (popped[i] && fq[i].size() != 0) tmp = fq[i].pop_front();
    @(negedge clk);
  endtask

  task automatic cyc();
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    settle();
    adv();
  endtask

  task automatic run_idle(input int budget, input string tag);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    while (!done && n < budget) begin
      cyc();
      n++;
      done = !out_valid && !busy;
      for (int i = 0; i < NQ; i++) if (fq[i].size() != 0) done = 0;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    out_ready = 1'b1;
    drive_fifos();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    got.delete();
    legal_err = 0;
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < NQ; i++) begin
      fq[i].delete();
      src[i].delete();
    end
    exp_q.delete();
  endtask

  task automatic fill(input int q, input int n, input bit rnd);
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      d = rnd ? 8'($urandom) : dat(q, k);
      fq[q].push_back(d);
      src[q].push_back(d);
    end
  endtask

  task automatic exp_from_seq(input string s);
    int seen[NQ];
    int q;
    for (int i = 0; i < NQ; i++) seen[i] = 0;
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      q = int'(s[i]) - 48;
      exp_q.push_back({6'b0, 2'(q), dat(q, seen[q])});
      seen[q]++;
    end
  endtask

  // Reference: grant the next non-empty queue after the last grant, take up to BMAX words.
  task automatic build_exp();
    logic [7:0] rem[NQ][$];
    int ptr, total, pick, n;
    for (int i = 0; i < NQ; i++) rem[i] = src[i];
    exp_q.delete();
    ptr = NQ - 1;
    total = 0;
    for (int i = 0; i < NQ; i++) total += rem[i].size();
    while (total > 0) begin
      pick = -1;
      for (int off = 1; off <= NQ; off++)
        if (pick < 0 && rem[(ptr + off) % NQ].size() != 0) pick = (ptr + off) % NQ;
      n = (rem[pick].size() < BMAX) ? rem[pick].size() : BMAX;
      for (int j = 0; j < n; j++) exp_q.push_back({6'b0, 2'(pick), rem[pick].pop_front()});
      total -= n;
      ptr = pick;
    end
  endtask

  task automatic cmp_got(input string tag);
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    check({tag, "_pop_legal"}, legal_err, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    out_ready = 1'b1;
    q_empty = '1;
    q_data = '0;
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_qid", out_qid, 0);
    check("rst_q_pop", q_pop, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);

    // Two words on q0, latency and back-to-back pops.
    do_reset();
    clear_fifos();
    fq[0].push_back(8'h11);
    fq[0].push_back(8'h22);
    enable = 1'b1;
    settle(); check("b_pop_c1", q_pop, 0); adv();
    settle(); check("b_pop_c2", q_pop, 4'b0001); check("b_valid_c2", out_valid, 0); adv();
    settle(); check("b_pop_c3", q_pop, 4'b0001); check("b_data_c3", out_data, 8'h11);
    check("b_qid_c3", out_qid, 0); check("b_valid_c3", out_valid, 1); adv();
    settle(); check("b_pop_c4", q_pop, 0); check("b_data_c4", out_data, 8'h22); adv();
    settle(); check("b_busy_c5", busy, 0); check("b_valid_c5", out_valid, 0); adv();
    check("b_count", got.size(), 2);

    // Table vectors: preload counts, expected qid order.
    vecs[0] = mk(2, 0, 0, 0, "00");
    vecs[1] = mk(0, 6, 0, 6, "111133331133");
    vecs[2] = mk(1, 1, 1, 1, "0123");
    vecs[3] = mk(0, 0, 5, 0, "22222");
    vecs[4] = mk(3, 0, 2, 0, "00022");
    vecs[5] = mk(5, 5, 0, 0, "0000111101");
    vecs[6] = mk(0, 0, 0, 9, "333333333");
    vecs[7] = mk(4, 0, 4, 0, "00002222");
    for (int v = 0; v < 8; v++) begin
      do_reset();
      clear_fifos();
      fill(0, vecs[v].c0, 0); fill(1, vecs[v].c1, 0);
      fill(2, vecs[v].c2, 0); fill(3, vecs[v].c3, 0);
      exp_from_seq(vecs[v].seq);
      enable = 1'b1;
      run_idle(200, $sformatf("vec%0d", v));
      cmp_got($sformatf("vec%0d", v));
    end

    // Back-pressure for 5 cycles mid-burst.
    do_reset();
    clear_fifos();
    fill(1, 4, 0);
    enable = 1'b1;
    cyc(); cyc();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("bp_valid%0d", i), out_valid, 1);
      check($sformatf("bp_data%0d", i), out_data, dat(1, 0));
      check($sformatf("bp_pop%0d", i), q_pop, 0);
      adv();
    end
    out_ready = 1'b1;
    run_idle(100, "bp");
    exp_from_seq("1111");
    cmp_got("bp");

    // Enable dropped mid-burst on q2.
    do_reset();
    clear_fifos();
    fill(2, 4, 0);
    fill(3, 2, 0);
    enable = 1'b1;
    cyc(); cyc();
    enable = 1'b0;
    settle(); check("en_pop_off", q_pop, 0); check("en_pending", out_valid, 1); adv();
    for (int i = 0; i < 3; i++) begin
      settle(); check($sformatf("en_nopop%0d", i), q_pop, 0); adv();
    end
    check("en_drained", out_valid, 0);
    check("en_q2_left", fq[2].size(), 3);
    enable = 1'b1;
    run_idle(100, "en");
    exp_from_seq("233222");
    cmp_got("en");

    // Wrap-around: last grant q3, then q0 and q2 pending.
    do_reset();
    clear_fifos();
    fill(3, 1, 0);
    enable = 1'b1;
    run_idle(50, "wrap_a");
    got.delete();
    fill(0, 1, 0);
    fill(2, 1, 0);
    exp_from_seq("02");
    run_idle(50, "wrap");
    cmp_got("wrap");

    // Reset asserted during a burst.
    do_reset();
    clear_fifos();
    fill(1, 4, 0);
    enable = 1'b1;
    cyc(); cyc(); cyc();
    rst_n = 1'b0;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_data", out_data, 0);
    check("mr_qid", out_qid, 0);
    check("mr_pop", q_pop, 0);
    check("mr_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    got.delete();
    fq[3].push_back(dat(3, 0));
    run_idle(50, "mr");
    check("mr_len", got.size(), 3);
    if (got.size() == 3) begin
      check("mr_first", 32'(got[0]), {16'h0, 6'b0, 2'd1, dat(1, 2)});
      check("mr_last", 32'(got[2]), {16'h0, 6'b0, 2'd3, dat(3, 0)});
    end

    // Random preloads with random back-pressure against the reference model.
    for (int t = 0; t < 20; t++) begin
      do_reset();
      clear_fifos();
      for (int q = 0; q < NQ; q++) fill(q, $urandom_range(0, 9), 1);
      build_exp();
      enable = 1'b1;
      rand_ready = 1;
      run_idle(400, $sformatf("rnd%0d", t));
      rand_ready = 0;
      out_ready = 1'b1;
      cmp_got($sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
